// File: rtl/prescaled_counter_bank.sv
// prescaled_counter_bank: independent up/down, periodic/one-shot counters
// stepped every cycle or on a shared prescaler tick.
module prescaled_counter_bank #(
    parameter int NUM_CH         = 4,
    parameter int CTR_WIDTH      = 24,
    parameter int PRESCALE_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          use_prescaler,
    input  logic [PRESCALE_WIDTH-1:0]     prescale_limit,
    input  logic [NUM_CH-1:0]             ch_en,
    input  logic [NUM_CH-1:0]             ch_down,
    input  logic [NUM_CH-1:0]             ch_oneshot,
    input  logic [NUM_CH-1:0]             ch_load,
    input  logic [NUM_CH*CTR_WIDTH-1:0]   load_value,
    input  logic [NUM_CH*CTR_WIDTH-1:0]   ch_limit,
    output logic [NUM_CH*CTR_WIDTH-1:0]   count,
    output logic [NUM_CH-1:0]             tc,
    output logic [NUM_CH-1:0]             done,
    output logic                          tick
);
    logic [PRESCALE_WIDTH-1:0] prescale;

    // >= rather than == so a lowered limit pulls the prescaler back to 0 at once
    always_ff @(posedge clk)
        prescale <= (rst || prescale >= prescale_limit) ? '0 : prescale + 1'b1;

    assign tick = ~use_prescaler | (prescale == prescale_limit);

    genvar i;
    generate
        for (i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CTR_WIDTH-1:0] cnt, lim;
            logic                 tc_r, done_r, step, at_term;
            assign lim     = ch_limit[i*CTR_WIDTH +: CTR_WIDTH];
            assign step    = tick & ch_en[i] & ~done_r;
            assign at_term = ch_down[i] ? (cnt == '0) : (cnt == lim);
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt    <= '0;
                    tc_r   <= 1'b0;
                    done_r <= 1'b0;
                end else if (ch_load[i]) begin
                    cnt    <= load_value[i*CTR_WIDTH +: CTR_WIDTH];
                    tc_r   <= 1'b0;
                    done_r <= 1'b0;
                end else begin
                    tc_r <= step & at_term;
                    if (step & at_term) begin
                        done_r <= ch_oneshot[i];
                        if (!ch_oneshot[i]) cnt <= ch_down[i] ? lim : '0;
                    end else if (step) begin
                        cnt <= ch_down[i] ? cnt - 1'b1 : cnt + 1'b1;
                    end
                end
            end
            assign count[i*CTR_WIDTH +: CTR_WIDTH] = cnt;
            assign tc[i]   = tc_r;
            assign done[i] = done_r;
        end
    endgenerate
endmodule

// File: tb/tb_prescaled_counter_bank.sv
// tb_prescaled_counter_bank: table-driven vectors plus prescaler sequences.
module tb_prescaled_counter_bank;
    logic        clk = 1'b0;
    logic        rst, use_prescaler;
    logic [3:0]  prescale_limit;
    logic [1:0]  ch_en, ch_down, ch_oneshot, ch_load, tc, done;
    logic [15:0] load_value, ch_limit, count;
    logic        tick;
    int          n_cmp = 0, n_bad = 0;

    prescaled_counter_bank #(.NUM_CH(2), .CTR_WIDTH(8), .PRESCALE_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .use_prescaler(use_prescaler), .prescale_limit(prescale_limit),
        .ch_en(ch_en), .ch_down(ch_down), .ch_oneshot(ch_oneshot), .ch_load(ch_load),
        .load_value(load_value), .ch_limit(ch_limit), .count(count), .tc(tc), .done(done),
        .tick(tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [1:0] en, dn, os, ld;
        logic [7:0] lv0, lv1, lim0, lim1, c0, c1;
        logic [1:0] tc, done;
    } vec_t;

    vec_t tbl[33];

    function automatic vec_t mk(logic r, logic [1:0] en, logic [1:0] dn, logic [1:0] os,
                                logic [1:0] ld, logic [7:0] lv0, logic [7:0] lv1,
                                logic [7:0] lim0, logic [7:0] lim1, logic [7:0] c0,
                                logic [7:0] c1, logic [1:0] t, logic [1:0] d);
        vec_t v;
        v.r = r; v.en = en; v.dn = dn; v.os = os; v.ld = ld;
        v.lv0 = lv0; v.lv1 = lv1; v.lim0 = lim0; v.lim1 = lim1;
        v.c0 = c0; v.c1 = c1; v.tc = t; v.done = d;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0]  = mk(1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'd3, 8'd7, 8'h00, 8'h00, 2'b00, 2'b00);
        tbl[1]  = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'd3, 8'd7, 8'h01, 8'h00, 2'b00, 2'b00);
        tbl[2]  = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'd3, 8'd7, 8'h02, 8'h00, 2'b00, 2'b00);
        tbl[3]  = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'd3, 8'd7, 8'h03, 8'h00, 2'b00, 2'b00);
        tbl[4]  = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'd3, 8'd7, 8'h00, 8'h00, 2'b01, 2'b00);
        tbl[5]  = mk(0, 2'b01, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'd3, 8'd7, 8'h01, 8'h00, 2'b00, 2'b00);
        tbl[6]  = mk(0, 2'b01, 2'b10, 2'b10, 2'b10, 8'h00, 8'h02, 8'd3, 8'd7, 8'h02, 8'h02, 2'b00, 2'b00);
        tbl[7]  = mk(0, 2'b11, 2'b10, 2'b10, 2'b00, 8'h00, 8'h02, 8'd3, 8'd7, 8'h03, 8'h01, 2'b00, 2'b00);
        tbl[8]  = mk(0, 2'b11, 2'b10, 2'b10, 2'b00, 8'h00, 8'h02, 8'd3, 8'd7, 8'h00, 8'h00, 2'b01, 2'b00);
        tbl[9]  = mk(0, 2'b11, 2'b10, 2'b10, 2'b00, 8'h00, 8'h02, 8'd3, 8'd7, 8'h01, 8'h00, 2'b10, 2'b10);
        tbl[10] = mk(0, 2'b11, 2'b10, 2'b10, 2'b00, 8'h00, 8'h02, 8'd3, 8'd7, 8'h02, 8'h00, 2'b00, 2'b10);
        tbl[11] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 8'h00, 8'h02, 8'd3, 8'd7, 8'h03, 8'h00, 2'b00, 2'b10);
        tbl[12] = mk(0, 2'b11, 2'b10, 2'b00, 2'b10, 8'h00, 8'h05, 8'd3, 8'd7, 8'h00, 8'h05, 2'b01, 2'b00);
        tbl[13] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 8'h00, 8'h05, 8'd3, 8'd7, 8'h01, 8'h04, 2'b00, 2'b00);
        tbl[14] = mk(0, 2'b11, 2'b10, 2'b00, 2'b01, 8'h40, 8'h05, 8'd3, 8'd7, 8'h40, 8'h03, 2'b00, 2'b00);
        tbl[15] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 8'h40, 8'h05, 8'd3, 8'd7, 8'h41, 8'h02, 2'b00, 2'b00);
        tbl[16] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 8'h40, 8'h05, 8'd3, 8'd7, 8'h42, 8'h01, 2'b00, 2'b00);
        tbl[17] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 8'h40, 8'h05, 8'd3, 8'd7, 8'h43, 8'h00, 2'b00, 2'b00);
        tbl[18] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 8'h40, 8'h05, 8'd3, 8'd7, 8'h44, 8'h07, 2'b10, 2'b00);
        tbl[19] = mk(0, 2'b11, 2'b10, 2'b00, 2'b01, 8'h03, 8'h05, 8'd3, 8'd7, 8'h03, 8'h06, 2'b00, 2'b00);
        tbl[20] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 8'h03, 8'h05, 8'd3, 8'd7, 8'h00, 8'h05, 2'b01, 2'b00);
        tbl[21] = mk(0, 2'b11, 2'b10, 2'b00, 2'b11, 8'h03, 8'h00, 8'd3, 8'd7, 8'h03, 8'h00, 2'b00, 2'b00);
        tbl[22] = mk(0, 2'b11, 2'b10, 2'b00, 2'b00, 8'h03, 8'h00, 8'd3, 8'd7, 8'h00, 8'h07, 2'b11, 2'b00);
        tbl[23] = mk(0, 2'b00, 2'b10, 2'b00, 2'b00, 8'h03, 8'h00, 8'd3, 8'd7, 8'h00, 8'h07, 2'b00, 2'b00);
        tbl[24] = mk(0, 2'b00, 2'b10, 2'b00, 2'b01, 8'hFE, 8'h00, 8'd3, 8'd7, 8'hFE, 8'h07, 2'b00, 2'b00);
        tbl[25] = mk(0, 2'b01, 2'b10, 2'b00, 2'b00, 8'hFE, 8'h00, 8'd3, 8'd7, 8'hFF, 8'h07, 2'b00, 2'b00);
        tbl[26] = mk(0, 2'b01, 2'b10, 2'b00, 2'b00, 8'hFE, 8'h00, 8'd3, 8'd7, 8'h00, 8'h07, 2'b00, 2'b00);
        tbl[27] = mk(0, 2'b01, 2'b10, 2'b00, 2'b00, 8'hFE, 8'h00, 8'd3, 8'd7, 8'h01, 8'h07, 2'b00, 2'b00);
        tbl[28] = mk(0, 2'b01, 2'b10, 2'b01, 2'b01, 8'h02, 8'h00, 8'd3, 8'd7, 8'h02, 8'h07, 2'b00, 2'b00);
        tbl[29] = mk(0, 2'b01, 2'b10, 2'b01, 2'b00, 8'h02, 8'h00, 8'd3, 8'd7, 8'h03, 8'h07, 2'b00, 2'b00);
        tbl[30] = mk(0, 2'b01, 2'b10, 2'b01, 2'b00, 8'h02, 8'h00, 8'd3, 8'd7, 8'h03, 8'h07, 2'b01, 2'b01);
        tbl[31] = mk(0, 2'b01, 2'b10, 2'b01, 2'b00, 8'h02, 8'h00, 8'd3, 8'd7, 8'h03, 8'h07, 2'b00, 2'b01);
        tbl[32] = mk(1, 2'b11, 2'b10, 2'b01, 2'b11, 8'h55, 8'h55, 8'd3, 8'd7, 8'h00, 8'h00, 2'b00, 2'b00);

        use_prescaler = 1'b0;
        prescale_limit = 4'd0;
        #2;
        for (int k = 0; k < 33; k++) begin
            rst = tbl[k].r; ch_en = tbl[k].en; ch_down = tbl[k].dn;
            ch_oneshot = tbl[k].os; ch_load = tbl[k].ld;
            load_value = {tbl[k].lv1, tbl[k].lv0};
            ch_limit = {tbl[k].lim1, tbl[k].lim0};
            clk1();
            chk("count0", k, count[7:0], tbl[k].c0);
            chk("count1", k, count[15:8], tbl[k].c1);
            chk("tc", k, tc, tbl[k].tc);
            chk("done", k, done, tbl[k].done);
            chk("tick_nopre", k, tick, 1'b1);
        end

        // prescaler at limit 9: one tick every 10 cycles
        rst = 1'b1; use_prescaler = 1'b1; prescale_limit = 4'd9;
        ch_en = 2'b01; ch_down = 2'b00; ch_oneshot = 2'b00; ch_load = 2'b00;
        ch_limit = 16'h07FF; load_value = 16'h0000;
        clk1();
        chk("tick_in_rst", 0, tick, 1'b0);
        chk("count0_rst", 0, count[7:0], 8'd0);
        rst = 1'b0;
        for (int n = 1; n <= 26; n++) begin
            clk1();
            chk("tick_lim9", n, tick, (n % 10 == 9));
            if (n == 9)  chk("count0_c9", n, count[7:0], 8'd0);
            if (n == 10) chk("count0_c10", n, count[7:0], 8'd1);
            if (n == 20) chk("count0_c20", n, count[7:0], 8'd2);
        end
        // prescale now 6; dropping the limit to 3 must restart without a tick
        prescale_limit = 4'd3;
        #1;
        chk("tick_drop", 0, tick, 1'b0);
        clk1();
        chk("tick_after_drop", 0, tick, 1'b0);
        chk("count0_drop", 0, count[7:0], 8'd2);
        for (int n = 1; n <= 8; n++) begin
            clk1();
            chk("tick_lim3", n, tick, (n % 4 == 3));
            if (n == 3) chk("count0_l3a", n, count[7:0], 8'd2);
            if (n == 4) chk("count0_l3b", n, count[7:0], 8'd3);
            if (n == 8) chk("count0_l3c", n, count[7:0], 8'd4);
        end
        prescale_limit = 4'd0;
        #1;
        chk("tick_lim0", 0, tick, 1'b1);
        for (int n = 1; n <= 3; n++) begin
            clk1();
            chk("tick_lim0", n, tick, 1'b1);
            chk("count0_lim0", n, count[7:0], 8'(4 + n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/prescaled_counter_bank.md
PRESCALED_COUNTER_BANK -- requirements
Module: prescaled_counter_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent counter channels (1..8).
REQ-002 SHALL have parameter CTR_WIDTH, default 24, bits per channel counter.
REQ-003 SHALL have parameter PRESCALE_WIDTH, default 16, bits of the shared prescaler.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 use_prescaler  input  1  1: channels step on prescaler tick; 0: channels step every cycle.
REQ-007 prescale_limit  input  PRESCALE_WIDTH  prescaler terminal value; tick period is prescale_limit+1 cycles.
REQ-008 ch_en  input  NUM_CH  per-channel count enable.
REQ-009 ch_down  input  NUM_CH  per-channel direction; 0 up, 1 down.
REQ-010 ch_oneshot  input  NUM_CH  per-channel mode; 0 periodic, 1 one-shot.
REQ-011 ch_load  input  NUM_CH  per-channel synchronous load strobe.
REQ-012 load_value  input  NUM_CH*CTR_WIDTH  packed load values, channel i at [i*CTR_WIDTH +: CTR_WIDTH].
REQ-013 ch_limit  input  NUM_CH*CTR_WIDTH  packed terminal/reload values, same packing.
REQ-014 count  output  NUM_CH*CTR_WIDTH  packed registered counter values.
REQ-015 tc  output  NUM_CH  registered one-cycle terminal-count pulse per channel.
REQ-016 done  output  NUM_CH  registered one-shot completion flag per channel.
REQ-017 tick  output  1  registered-state-derived step strobe shared by all channels.

Function
REQ-018 Prescaler: on clock, prescale SHALL become 0 when prescale >= prescale_limit, else prescale+1.
REQ-019 tick SHALL be 1 when use_prescaler=0, else 1 exactly when prescale == prescale_limit (combinational from prescaler register); prescale_limit=0 gives tick every cycle.
REQ-020 prescale_limit lowered below current prescale SHALL cause prescale to return to 0 on the next clock, with no tick in that cycle.
REQ-021 Prescaler SHALL run continuously regardless of use_prescaler and ch_en.
REQ-022 Channel priority per clock: ch_load, then step; ch_load SHALL set count=load_value, clear done, and suppress tc for that cycle.
REQ-023 Step condition: tick & ch_en & ~done; otherwise count, done hold and tc=0.
REQ-024 Up step: count != ch_limit -> count+1; count == ch_limit -> tc=1 next cycle and count=0 (periodic) or count held, done=1 (one-shot).
REQ-025 Down step: count != 0 -> count-1; count == 0 -> tc=1 next cycle and count=ch_limit (periodic) or count held at 0, done=1 (one-shot).
REQ-026 Up count above ch_limit SHALL increment modulo 2^CTR_WIDTH until reaching ch_limit; no early wrap.
REQ-027 tc SHALL be high for exactly one cycle per terminal event, coincident with the wrapped/held value on count.
REQ-028 Changing ch_oneshot from 1 to 0 while done=1 SHALL not clear done; only ch_load or rst clears it.
REQ-029 Channels SHALL be fully independent; simultaneous events on different channels all take effect in the same cycle.

Reset
REQ-030 rst=1 SHALL set prescale=0, every count=0, tc=0, done=0 on the next clock, overriding ch_load and step.
REQ-031 During rst, tick SHALL follow REQ-019 from the reset prescaler value; outputs SHALL be valid the first cycle after rst deasserts.

Verification (NUM_CH=2, CTR_WIDTH=8, PRESCALE_WIDTH=4)
REQ-032 use_prescaler=1, prescale_limit=9, ch0 up periodic, ch_limit=255 -> tick every 10 cycles; count0 = 1 after 10 cycles, 2 after 20.
REQ-033 use_prescaler=0, ch0 up periodic, ch_limit=3 -> count0 0,1,2,3,0,1; tc0 high only in cycles where count0 shows 0 after 3.
REQ-034 ch1 down one-shot, load_value=2, ch_limit=7, use_prescaler=0 -> count1 2,1,0,0,...; tc1 one pulse; done1=1 and held; ch_load then clears done1.
REQ-035 ch_load and step same cycle, load_value=0x40 -> count=0x40, tc=0; both channels stepping, one wrapping -> independent results same cycle.
REQ-036 prescale_limit 9->3 while prescale=6 -> prescale=0 next cycle, no tick, then tick every 4 cycles; rst mid-count -> count=0, done=0, tc=0 next cycle.
